// File: rtl/apb_i2c_fifo_regif.sv
// APB slave register interface for the I2C core: TX/RX FIFOs, status, config/timeout
// registers and maskable sticky interrupts with a registered IRQ.
module apb_i2c_fifo_regif #(
    parameter int unsigned     DATA_W     = 32,
    parameter int unsigned     FIFO_DEPTH = 8,
    parameter int unsigned     ADDR_W     = 8,
    parameter int unsigned     CFG_W      = 14,
    parameter logic [CFG_W-1:0] CFG_RST   = '0,
    parameter logic [CFG_W-1:0] TMO_RST   = '0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    input  logic              CORE_ERROR,
    output logic [CFG_W-1:0]  I2C_CONFIG,
    output logic [CFG_W-1:0]  I2C_TIMEOUT,
    output logic              IRQ
);

    localparam int unsigned     PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    localparam logic [ADDR_W-1:0] AddrTxData  = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] AddrRxData  = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] AddrConfig  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] AddrTimeout = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] AddrStatus  = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] AddrIntEn   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] AddrIntStat = ADDR_W'(32'h18);

    logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] tx_mem_d [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem_d [FIFO_DEPTH];

    logic [PtrW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PtrW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CntW-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [CFG_W-1:0] cfg_q, cfg_d, tmo_q, tmo_d;
    logic [3:0]       int_en_q, int_en_d;
    logic             ovf_q, ovf_d;
    logic             cerr_q, cerr_d;
    logic             cerr_prev_q;
    logic             irq_q, irq_d;

    logic       access, mapped, err, wr_ok, rd_ok;
    logic       sel_tx, sel_rx, sel_cfg, sel_tmo, sel_st, sel_ien, sel_ist;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       ovf_set, cerr_set;
    logic [1:0] w1c;
    logic [3:0] int_stat;
    logic [31:0] status;
    logic       unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FullCnt);

    // Unaligned addresses never match an aligned constant, so they fall out as unmapped.
    always_comb begin
        access  = PSELx & PENABLE;
        sel_tx  = (PADDR == AddrTxData);
        sel_rx  = (PADDR == AddrRxData);
        sel_cfg = (PADDR == AddrConfig);
        sel_tmo = (PADDR == AddrTimeout);
        sel_st  = (PADDR == AddrStatus);
        sel_ien = (PADDR == AddrIntEn);
        sel_ist = (PADDR == AddrIntStat);
        mapped  = sel_tx | sel_rx | sel_cfg | sel_tmo | sel_st | sel_ien | sel_ist;
        err     = 1'b0;
        if (access) begin
            if (!mapped) begin
                err = 1'b1;
            end else if (PWRITE && (sel_rx || sel_st)) begin
                err = 1'b1;
            end else if (!PWRITE && sel_tx) begin
                err = 1'b1;
            end else if (PWRITE && sel_tx && tx_full) begin
                err = 1'b1;
            end else if (!PWRITE && sel_rx && rx_empty) begin
                err = 1'b1;
            end
        end
        wr_ok = access & PWRITE & ~err;
        rd_ok = access & ~PWRITE & ~err;
    end

    assign PREADY  = access;
    assign PSLVERR = err;

    assign tx_push  = wr_ok & sel_tx;
    assign tx_pop   = ~tx_empty & TX_READY;
    assign rx_pop   = rd_ok & sel_rx;
    // A same-cycle APB pop frees the slot, so a full RX FIFO can still accept the word.
    assign rx_push  = RX_VALID & (~rx_full | rx_pop);
    assign ovf_set  = RX_VALID & rx_full & ~rx_pop;
    assign cerr_set = CORE_ERROR & ~cerr_prev_q;
    assign w1c      = (wr_ok & sel_ist) ? PWDATA[3:2] : 2'b00;

    assign int_stat = {cerr_q, ovf_q, ~rx_empty, tx_empty};
    assign status   = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                       rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = PWDATA[DATA_W-1:0];
            tx_wptr_d           = tx_wptr_q + PtrW'(1);
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + PtrW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CntW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CntW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = RX_DATA;
            rx_wptr_d           = rx_wptr_q + PtrW'(1);
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + PtrW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CntW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CntW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // Hardware set wins over a same-cycle W1C.
    always_comb begin
        cfg_d    = cfg_q;
        tmo_d    = tmo_q;
        int_en_d = int_en_q;
        if (wr_ok && sel_cfg) begin
            cfg_d = PWDATA[CFG_W-1:0];
        end
        if (wr_ok && sel_tmo) begin
            tmo_d = PWDATA[CFG_W-1:0];
        end
        if (wr_ok && sel_ien) begin
            int_en_d = PWDATA[3:0];
        end
        ovf_d  = ovf_set | (ovf_q & ~w1c[0]);
        cerr_d = cerr_set | (cerr_q & ~w1c[1]);
        irq_d  = |(int_stat & int_en_q);
    end

    always_comb begin
        PRDATA = '0;
        if (rd_ok) begin
            unique case (1'b1)
                sel_rx:  PRDATA = 32'(rx_mem_q[rx_rptr_q]);
                sel_cfg: PRDATA = 32'(cfg_q);
                sel_tmo: PRDATA = 32'(tmo_q);
                sel_st:  PRDATA = status;
                sel_ien: PRDATA = {28'h0, int_en_q};
                sel_ist: PRDATA = {28'h0, int_stat};
                default: PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            cfg_q       <= CFG_RST;
            tmo_q       <= TMO_RST;
            int_en_q    <= '0;
            ovf_q       <= 1'b0;
            cerr_q      <= 1'b0;
            cerr_prev_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            cfg_q       <= cfg_d;
            tmo_q       <= tmo_d;
            int_en_q    <= int_en_d;
            ovf_q       <= ovf_d;
            cerr_q      <= cerr_d;
            cerr_prev_q <= CORE_ERROR;
            irq_q       <= irq_d;
        end
    end

    assign TX_DATA     = tx_mem_q[tx_rptr_q];
    assign TX_VALID    = ~tx_empty;
    assign RX_READY    = ~rx_full;
    assign I2C_CONFIG  = cfg_q;
    assign I2C_TIMEOUT = tmo_q;
    assign IRQ         = irq_q;

endmodule

// File: doc/apb_i2c_fifo_regif.md
# apb_i2c_fifo_regif

Parametrised APB slave register interface for the I2C core. It sits between the APB bus and the I2C byte engine and adds what the plain register interface lacks: internal TX and RX FIFOs of configurable depth, a status register and maskable sticky interrupts. It also returns PSLVERR on illegal accesses and holds I2C configuration and timeout registers of configurable width.

## Interface
- DATA_W, 32: width of TX/RX data words (1..32); PWDATA/PRDATA upper bits beyond DATA_W ignored/zero
- FIFO_DEPTH, 8: entries per FIFO, power of two, 2..128
- ADDR_W, 8: PADDR width
- CFG_W, 14: width of CONFIG and TIMEOUT registers (1..32)
- CFG_RST, 0: reset value of CONFIG
- TMO_RST, 0: reset value of TIMEOUT
- PCLK  in  1  bus and block clock, all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSELx, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  ADDR_W  byte address; PWDATA  in  32  write data
- PRDATA  out  32  read data; PREADY  out  1; PSLVERR  out  1
- TX_DATA  out  DATA_W  head of TX FIFO; TX_VALID  out  1  TX FIFO not empty; TX_READY  in  1  core pops head
- RX_DATA  in  DATA_W; RX_VALID  in  1  core pushes (no backpressure); RX_READY  out  1  RX FIFO not full
- CORE_ERROR  in  1  level error from I2C core
- I2C_CONFIG  out  CFG_W; I2C_TIMEOUT  out  CFG_W
- IRQ  out  1  registered interrupt request

## Operation
- Register map (word aligned): 0x00 TXDATA W; 0x04 RXDATA R; 0x08 CONFIG RW; 0x0C TIMEOUT RW; 0x10 STATUS R; 0x14 INT_EN RW [3:0]; 0x18 INT_STAT R, W1C on bits [3:2].
- STATUS: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_count, [23:16] rx_count (0..FIFO_DEPTH); other bits 0.
- INT_STAT: [0] tx_empty (level), [1] rx_not_empty (level), [2] rx_overflow (sticky), [3] core_error (sticky, set on 0->1 edge of CORE_ERROR).
- APB: zero wait states; PREADY = PSELx & PENABLE. Transfer completes in the ACCESS cycle; side effects (push, pop, register write, W1C) take effect at the PCLK edge ending it.
- PSLVERR=1 in ACCESS, and the transfer has no side effect, for: unmapped or unaligned address; write to 0x04/0x10; read of 0x00; TXDATA write while tx_full; RXDATA read while rx_empty. Full/empty are judged on pre-edge state.
- PRDATA combinational during read ACCESS with no error, zero otherwise; RXDATA read returns zero-extended head and pops it.
- TX side: pop when TX_VALID & TX_READY. APB push and core pop in the same cycle both happen, count unchanged.
- RX side: push when RX_VALID & !rx_full. If RX_VALID while full: word dropped, rx_overflow set, unless an APB RXDATA pop occurs the same cycle, in which case the push is accepted.
- Sticky bits: a hardware set and W1C in the same cycle leaves the bit set.
- IRQ = registered |(INT_STAT & INT_EN).

## Timing
- Reset (async assert, sync-safe release): FIFOs empty, pointers/counts 0, CONFIG=CFG_RST, TIMEOUT=TMO_RST, INT_EN=0, sticky bits 0, previous CORE_ERROR sample 0, IRQ=0.
- Combinational outputs during reset: TX_VALID=0, RX_READY=1, PREADY per inputs, PSLVERR/PRDATA 0 outside ACCESS.
- Reset mid-transfer aborts the transfer and flushes both FIFOs.
- CONFIG/TIMEOUT outputs change the cycle after the write ACCESS.
- TX_VALID rises the cycle after the first push. RX word is readable via APB the cycle after its push.
- IRQ follows an INT_STAT or INT_EN change by exactly one cycle.
- Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.

## Test plan
- Reset, then read 0x10 -> 0x0000_0005 (tx_empty, rx_empty); read 0x08 -> CFG_RST; IRQ=0.
- With TX_READY=0 and FIFO_DEPTH=8, write 0xA0..0xA8 to 0x00 -> first 8 OKAY, 9th PSLVERR=1; STATUS tx_count=8, tx_full=1. Then TX_READY=1 -> TX_DATA sequence 0xA0..0xA7 in order.
- Core pushes 9 words with RX_VALID held, no APB reads -> rx_count=8, INT_STAT[2]=1. With INT_EN=0x4, IRQ=1 one cycle after the set. Write 0x4 to 0x18 -> bit clears, IRQ drops next cycle.
- RX full, APB RXDATA read in the same cycle as RX_VALID -> read returns oldest word, new word accepted, rx_count stays 8, no overflow.
- Read 0x04 while empty, write 0x10, access 0x1C -> PSLVERR=1 each, no state change. Write 0x3FFF to 0x08 -> I2C_CONFIG=0x3FFF next cycle.
- Pulse CORE_ERROR high for 3 cycles -> INT_STAT[3] set once. W1C issued in the same cycle as a new rising edge -> bit remains 1.
